// File: rtl/layer_sequencer_if.sv
// Bus bundle between the layer sequencer and its host: descriptor writes, run control,
// RAM address/strobe outputs and run status.
interface layer_sequencer_if #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned WADDR_W = 12
);
    logic               cfg_wr_en;
    logic [1:0]         cfg_layer_idx;
    logic [ADDR_W-1:0]  cfg_in_count;
    logic [ADDR_W-1:0]  cfg_out_count;
    logic [2:0]         num_layers;
    logic               start;

    logic [ADDR_W-1:0]  neuro_read_address;
    logic [WADDR_W-1:0] weight_read_address;
    logic [ADDR_W-1:0]  neuro_write_address;
    logic               neuro_wr_en;
    logic               alu_clear;
    logic               alu_acc_en;
    logic               busy;
    logic               finished;
    logic               cfg_error;
    logic [ADDR_W-1:0]  result_base_address;
    logic [ADDR_W-1:0]  result_word_count;

    // Host side
    modport master (
        output cfg_wr_en, cfg_layer_idx, cfg_in_count, cfg_out_count, num_layers, start,
        input  neuro_read_address, weight_read_address, neuro_write_address, neuro_wr_en,
               alu_clear, alu_acc_en, busy, finished, cfg_error, result_base_address,
               result_word_count
    );

    // Sequencer side
    modport slave (
        input  cfg_wr_en, cfg_layer_idx, cfg_in_count, cfg_out_count, num_layers, start,
        output neuro_read_address, weight_read_address, neuro_write_address, neuro_wr_en,
               alu_clear, alu_acc_en, busy, finished, cfg_error, result_base_address,
               result_word_count
    );
endinterface

// File: rtl/layer_sequencer.sv
// Control FSM stepping the MAC ALU and neuron/weight RAMs through a stack of fully-connected
// layers; every output is a flop.
module layer_sequencer #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned WADDR_W    = 12,
    parameter int unsigned MAX_LAYERS = 4,
    parameter int unsigned ALU_LAT    = 1
) (
    input  logic                clk,
    input  logic                reset,
    layer_sequencer_if.slave    bus
);
    localparam int unsigned LayerW = 2;
    localparam int unsigned DrainW = $clog2(ALU_LAT + 2);

    typedef enum logic [2:0] {
        StIdle, StReject, StClear, StFetch, StDrain, StWrite, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   tbl_in_q  [MAX_LAYERS];
    logic [ADDR_W-1:0]   tbl_in_d  [MAX_LAYERS];
    logic [ADDR_W-1:0]   tbl_out_q [MAX_LAYERS];
    logic [ADDR_W-1:0]   tbl_out_d [MAX_LAYERS];
    logic                pend_q, pend_d;
    logic [LayerW-1:0]   pend_idx_q, pend_idx_d;
    logic [ADDR_W-1:0]   pend_in_q, pend_in_d;
    logic [ADDR_W-1:0]   pend_out_q, pend_out_d;
    logic [2:0]          num_layers_q, num_layers_d;
    logic [LayerW-1:0]   layer_q, layer_d;
    logic [ADDR_W-1:0]   in_base_q, in_base_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [ADDR_W-1:0]   j_q, j_d;
    logic [WADDR_W-1:0]  w_ptr_q, w_ptr_d;
    logic [DrainW-1:0]   drain_q, drain_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [WADDR_W-1:0]  wt_addr_q, wt_addr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                wr_en_q, wr_en_d;
    logic                clear_q, clear_d;
    logic                acc_en_q, acc_en_d;
    logic                busy_q, busy_d;
    logic                finished_q, finished_d;
    logic                cfg_error_q, cfg_error_d;
    logic [ADDR_W-1:0]   res_base_q, res_base_d;
    logic [ADDR_W-1:0]   res_cnt_q, res_cnt_d;

    logic [ADDR_W-1:0]   cur_in, cur_out, out_base;
    logic                cfg_bad, start_ok, j_last;

    assign cur_in   = tbl_in_q[layer_q];
    assign cur_out  = tbl_out_q[layer_q];
    assign out_base = in_base_q + cur_in;
    assign j_last   = (j_q == cur_out - ADDR_W'(1));
    assign start_ok = (state_q == StIdle) && bus.start;

    always_comb begin
        cfg_bad = (bus.num_layers == 3'd0) || (32'(bus.num_layers) > MAX_LAYERS);
        for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
            if (i < 32'(bus.num_layers) && (tbl_in_q[i] == '0 || tbl_out_q[i] == '0)) begin
                cfg_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        tbl_in_d     = tbl_in_q;
        tbl_out_d    = tbl_out_q;
        pend_d       = pend_q;
        pend_idx_d   = pend_idx_q;
        pend_in_d    = pend_in_q;
        pend_out_d   = pend_out_q;
        num_layers_d = num_layers_q;
        layer_d      = layer_q;
        in_base_d    = in_base_q;
        k_d          = k_q;
        j_d          = j_q;
        w_ptr_d      = w_ptr_q;
        drain_d      = drain_q;
        rd_addr_d    = rd_addr_q;
        wt_addr_d    = wt_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_en_d      = 1'b0;
        clear_d      = 1'b0;
        acc_en_d     = (state_q == StFetch);
        busy_d       = busy_q;
        finished_d   = finished_q;
        cfg_error_d  = cfg_error_q;
        res_base_d   = res_base_q;
        res_cnt_d    = res_cnt_q;

        // A write arriving with an accepted start is parked so the run sees the old table.
        if (state_q == StDone && pend_q) begin
            tbl_in_d[pend_idx_q]  = pend_in_q;
            tbl_out_d[pend_idx_q] = pend_out_q;
            pend_d                = 1'b0;
        end
        if (bus.cfg_wr_en && !busy_q && 32'(bus.cfg_layer_idx) < MAX_LAYERS) begin
            if (start_ok) begin
                pend_d     = 1'b1;
                pend_idx_d = bus.cfg_layer_idx;
                pend_in_d  = bus.cfg_in_count;
                pend_out_d = bus.cfg_out_count;
            end else begin
                tbl_in_d[bus.cfg_layer_idx]  = bus.cfg_in_count;
                tbl_out_d[bus.cfg_layer_idx] = bus.cfg_out_count;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    finished_d   = 1'b0;
                    cfg_error_d  = 1'b0;
                    busy_d       = 1'b1;
                    num_layers_d = bus.num_layers;
                    layer_d      = '0;
                    in_base_d    = '0;
                    j_d          = '0;
                    w_ptr_d      = '0;
                    if (cfg_bad) begin
                        state_d = StReject;
                    end else begin
                        state_d = StClear;
                        clear_d = 1'b1;
                    end
                end
            end
            StReject: begin
                state_d     = StDone;
                busy_d      = 1'b0;
                finished_d  = 1'b1;
                cfg_error_d = 1'b1;
            end
            StClear: begin
                state_d   = StFetch;
                rd_addr_d = in_base_q;
                wt_addr_d = w_ptr_q;
                w_ptr_d   = w_ptr_q + WADDR_W'(1);
                k_d       = ADDR_W'(1);
            end
            StFetch: begin
                if (k_q == cur_in) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    rd_addr_d = in_base_q + k_q;
                    wt_addr_d = w_ptr_q;
                    w_ptr_d   = w_ptr_q + WADDR_W'(1);
                    k_d       = k_q + ADDR_W'(1);
                end
            end
            StDrain: begin
                if (drain_q == DrainW'(ALU_LAT)) begin
                    state_d   = StWrite;
                    wr_en_d   = 1'b1;
                    wr_addr_d = out_base + j_q;
                end else begin
                    drain_d = drain_q + DrainW'(1);
                end
            end
            StWrite: begin
                if (!j_last) begin
                    j_d     = j_q + ADDR_W'(1);
                    state_d = StClear;
                    clear_d = 1'b1;
                end else if (32'(layer_q) + 32'd1 < 32'(num_layers_q)) begin
                    layer_d   = layer_q + LayerW'(1);
                    in_base_d = out_base;
                    j_d       = '0;
                    state_d   = StClear;
                    clear_d   = 1'b1;
                end else begin
                    state_d    = StDone;
                    busy_d     = 1'b0;
                    finished_d = 1'b1;
                    res_base_d = out_base;
                    res_cnt_d  = cur_out;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            tbl_in_q     <= '{default: '0};
            tbl_out_q    <= '{default: '0};
            pend_q       <= 1'b0;
            pend_idx_q   <= '0;
            pend_in_q    <= '0;
            pend_out_q   <= '0;
            num_layers_q <= '0;
            layer_q      <= '0;
            in_base_q    <= '0;
            k_q          <= '0;
            j_q          <= '0;
            w_ptr_q      <= '0;
            drain_q      <= '0;
            rd_addr_q    <= '0;
            wt_addr_q    <= '0;
            wr_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            clear_q      <= 1'b0;
            acc_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            cfg_error_q  <= 1'b0;
            res_base_q   <= '0;
            res_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            tbl_in_q     <= tbl_in_d;
            tbl_out_q    <= tbl_out_d;
            pend_q       <= pend_d;
            pend_idx_q   <= pend_idx_d;
            pend_in_q    <= pend_in_d;
            pend_out_q   <= pend_out_d;
            num_layers_q <= num_layers_d;
            layer_q      <= layer_d;
            in_base_q    <= in_base_d;
            k_q          <= k_d;
            j_q          <= j_d;
            w_ptr_q      <= w_ptr_d;
            drain_q      <= drain_d;
            rd_addr_q    <= rd_addr_d;
            wt_addr_q    <= wt_addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_en_q      <= wr_en_d;
            clear_q      <= clear_d;
            acc_en_q     <= acc_en_d;
            busy_q       <= busy_d;
            finished_q   <= finished_d;
            cfg_error_q  <= cfg_error_d;
            res_base_q   <= res_base_d;
            res_cnt_q    <= res_cnt_d;
        end
    end

    assign bus.neuro_read_address  = rd_addr_q;
    assign bus.weight_read_address = wt_addr_q;
    assign bus.neuro_write_address = wr_addr_q;
    assign bus.neuro_wr_en         = wr_en_q;
    assign bus.alu_clear           = clear_q;
    assign bus.alu_acc_en          = acc_en_q;
    assign bus.busy                = busy_q;
    assign bus.finished            = finished_q;
    assign bus.cfg_error           = cfg_error_q;
    assign bus.result_base_address = res_base_q;
    assign bus.result_word_count   = res_cnt_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: a reference model queues expected RAM addresses and
// per-neuron accumulate counts; a negedge monitor pops and compares them.
module tb_layer_sequencer;
    localparam int unsigned AW  = 10;
    localparam int unsigned WAW = 12;
    localparam int unsigned ML  = 4;
    localparam int unsigned LAT = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    layer_sequencer_if #(.ADDR_W(AW), .WADDR_W(WAW)) bus ();

    layer_sequencer #(
        .ADDR_W(AW), .WADDR_W(WAW), .MAX_LAYERS(ML), .ALU_LAT(LAT)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int rd_q[$];
    int wt_q[$];
    int wr_q[$];
    int cnt_q[$];
    int model_in[ML];
    int model_out[ML];
    bit mon_en = 1'b0;
    int acc_cnt = 0;
    int prev_rd = 0;
    int prev_wt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Read/weight addresses are compared one cycle late, when alu_acc_en marks their data.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.alu_clear) acc_cnt = 0;
            if (bus.alu_acc_en) begin
                acc_cnt++;
                if (rd_q.size() == 0) check_eq("acc_extra", rd_q.size(), 1);
                else begin
                    check_eq("rd_addr", prev_rd, rd_q.pop_front());
                    check_eq("wt_addr", prev_wt, wt_q.pop_front());
                end
            end
            if (bus.neuro_wr_en) begin
                if (wr_q.size() == 0) check_eq("wr_extra", wr_q.size(), 1);
                else begin
                    check_eq("wr_addr", bus.neuro_write_address, wr_q.pop_front());
                    check_eq("acc_count", acc_cnt, cnt_q.pop_front());
                end
            end
        end
        prev_rd = int'(bus.neuro_read_address);
        prev_wt = int'(bus.weight_read_address);
    end

    task automatic cfg_layer(input int idx, input int nin, input int nout);
        @(negedge clk);
        bus.cfg_wr_en     = 1'b1;
        bus.cfg_layer_idx = 2'(idx);
        bus.cfg_in_count  = AW'(nin);
        bus.cfg_out_count = AW'(nout);
        model_in[idx]     = nin;
        model_out[idx]    = nout;
        @(negedge clk);
        bus.cfg_wr_en = 1'b0;
    endtask

    // with_cfg drives a layer-0 descriptor write in the same cycle as start.
    task automatic run_layers(input int nl, input string tag, input bit with_cfg = 1'b0,
                              input int cin = 0);
        bit ok;
        int base, w, cyc_exp, res_base, res_cnt, cyc;
        ok = (nl > 0 && nl <= int'(ML));
        if (ok) for (int l = 0; l < nl; l++) if (model_in[l] == 0 || model_out[l] == 0) ok = 0;
        base = 0; w = 0; cyc_exp = 0; res_base = 0; res_cnt = 0;
        if (ok) begin
            for (int l = 0; l < nl; l++) begin
                for (int j = 0; j < model_out[l]; j++) begin
                    for (int k = 0; k < model_in[l]; k++) begin
                        rd_q.push_back((base + k) % 1024);
                        wt_q.push_back(w % 4096);
                        w++;
                    end
                    cnt_q.push_back(model_in[l]);
                    wr_q.push_back((base + model_in[l] + j) % 1024);
                    cyc_exp += model_in[l] + int'(LAT) + 3;
                end
                res_base = (base + model_in[l]) % 1024;
                res_cnt  = model_out[l];
                base     = res_base;
            end
        end
        @(negedge clk);
        bus.num_layers = 3'(nl);
        bus.start      = 1'b1;
        if (with_cfg) begin
            bus.cfg_wr_en     = 1'b1;
            bus.cfg_layer_idx = 2'd0;
            bus.cfg_in_count  = AW'(cin);
            bus.cfg_out_count = AW'(2);
        end
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.cfg_wr_en = 1'b0;
        if (with_cfg) begin
            model_in[0]  = cin;
            model_out[0] = 2;
        end
        check_eq({tag, "_busy_run"}, bus.busy, 1);
        check_eq({tag, "_fin_clr"}, bus.finished, 0);
        check_eq({tag, "_err_clr"}, bus.cfg_error, 0);
        cyc = 0;
        while (!bus.finished && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, "_finished"}, bus.finished, 1);
        check_eq({tag, "_busy_done"}, bus.busy, 0);
        check_eq({tag, "_cfg_error"}, bus.cfg_error, ok ? 0 : 1);
        if (ok) begin
            check_eq({tag, "_cycles"}, cyc, cyc_exp);
            check_eq({tag, "_base"}, bus.result_base_address, res_base);
            check_eq({tag, "_count"}, bus.result_word_count, res_cnt);
        end
        @(negedge clk);
        check_eq({tag, "_rd_left"}, rd_q.size(), 0);
        check_eq({tag, "_wr_left"}, wr_q.size(), 0);
        @(negedge clk);
        check_eq({tag, "_fin_held"}, bus.finished, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd"}, bus.neuro_read_address, 0);
        check_eq({tag, "_wt"}, bus.weight_read_address, 0);
        check_eq({tag, "_wa"}, bus.neuro_write_address, 0);
        check_eq({tag, "_we"}, bus.neuro_wr_en, 0);
        check_eq({tag, "_clr"}, bus.alu_clear, 0);
        check_eq({tag, "_acc"}, bus.alu_acc_en, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
        check_eq({tag, "_fin"}, bus.finished, 0);
        check_eq({tag, "_err"}, bus.cfg_error, 0);
        check_eq({tag, "_base"}, bus.result_base_address, 0);
        check_eq({tag, "_cnt"}, bus.result_word_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.cfg_wr_en = 1'b0; bus.cfg_layer_idx = '0; bus.cfg_in_count = '0;
        bus.cfg_out_count = '0; bus.num_layers = '0; bus.start = 1'b0;
        for (int i = 0; i < int'(ML); i++) begin model_in[i] = 0; model_out[i] = 0; end
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single layer 4->2, then two layers 4->3->2.
        cfg_layer(0, 4, 2);
        run_layers(1, "t1");
        cfg_layer(0, 4, 3);
        cfg_layer(1, 3, 2);
        run_layers(2, "t2");

        // Start and descriptor write mid-run must be ignored.
        cfg_layer(0, 4, 2);
        fork
            run_layers(1, "t3");
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                bus.start = 1'b1; bus.cfg_wr_en = 1'b1; bus.cfg_layer_idx = 2'd0;
                bus.cfg_in_count = AW'(9); bus.cfg_out_count = AW'(2);
                @(negedge clk);
                bus.start = 1'b0; bus.cfg_wr_en = 1'b0;
            end
        join
        run_layers(1, "t3b");

        // Same-cycle write+start: run uses old table, next run sees in=1.
        run_layers(1, "t7", 1'b1, 1);
        run_layers(1, "t7b");

        // Reset during FETCH of the second neuron.
        cfg_layer(0, 4, 2);
        mon_en = 1'b0;
        @(negedge clk);
        bus.num_layers = 3'd1;
        bus.start      = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("t4_pre_rd", bus.neuro_read_address, 1);
        check_eq("t4_pre_wt", bus.weight_read_address, 5);
        check_eq("t4_pre_acc", bus.alu_acc_en, 1);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("t4_rst");
        rd_q.delete(); wt_q.delete(); wr_q.delete(); cnt_q.delete();
        for (int i = 0; i < int'(ML); i++) begin model_in[i] = 0; model_out[i] = 0; end
        acc_cnt = 0;
        mon_en  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_layers(1, "t4_lost");
        cfg_layer(0, 4, 2);
        run_layers(1, "t4b");

        // Rejected configurations.
        run_layers(0, "t5_zero");
        run_layers(5, "t5_big");
        cfg_layer(0, 0, 2);
        run_layers(1, "t5_in0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
